// File: rtl/exec_alu_pkg.sv
// Shared encodings for the execute-stage ALU: operation codes, HI/LO read
// selects, word width and the divider FSM state type.
package exec_alu_pkg;

  localparam int WORD_W = 32;

  // ALU operation codes driven by decode-stage ALU control.
  localparam logic [3:0] ALU_NOP     = 4'h0;
  localparam logic [3:0] ALU_ADD     = 4'h1;
  localparam logic [3:0] ALU_SUB     = 4'h2;
  localparam logic [3:0] ALU_SLL     = 4'h3;
  localparam logic [3:0] ALU_SRA     = 4'h4;
  localparam logic [3:0] ALU_SLLI    = 4'h5;
  localparam logic [3:0] ALU_OR      = 4'h6;
  localparam logic [3:0] ALU_RS_PASS = 4'h7;
  localparam logic [3:0] ALU_DIV     = 4'h8;
  localparam logic [3:0] ALU_UNDEF   = 4'hF;

  // HI/LO read selects (2'b11 is reserved and behaves like HILO_NONE).
  localparam logic [1:0] HILO_NONE = 2'b00;
  localparam logic [1:0] HILO_LO   = 2'b01;
  localparam logic [1:0] HILO_HI   = 2'b10;

  typedef enum logic [1:0] {
    DIV_IDLE   = 2'd0,
    DIV_DIVIDE = 2'd1,
    DIV_FIXUP  = 2'd2
  } div_state_e;

endpackage

// File: rtl/seq_divider.sv
// Iterative signed restoring divider: one accept cycle, WIDTH divide steps,
// one sign fix-up cycle. Presents the final HI/LO values with a write strobe.
module seq_divider
  import exec_alu_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi_next,
  output logic [WIDTH-1:0] lo_next,
  output logic             hilo_we,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [WIDTH-1:0] a_raw_q, a_raw_d;
  logic             sign_q_q, sign_q_d;
  logic             sign_r_q, sign_r_d;
  logic             divzero_q, divzero_d;

  // One extra bit so a negative trial subtraction shows up as the MSB.
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // State and working registers; reset clears everything even mid-divide.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= DIV_IDLE;
      count_q   <= '0;
      rem_q     <= '0;
      quot_q    <= '0;
      divisor_q <= '0;
      a_raw_q   <= '0;
      sign_q_q  <= 1'b0;
      sign_r_q  <= 1'b0;
      divzero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      rem_q     <= rem_d;
      quot_q    <= quot_d;
      divisor_q <= divisor_d;
      a_raw_q   <= a_raw_d;
      sign_q_q  <= sign_q_d;
      sign_r_q  <= sign_r_d;
      divzero_q <= divzero_d;
    end
  end

  // Next-state logic: accept operands, run one restoring step per cycle, fix up.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    rem_d     = rem_q;
    quot_d    = quot_q;
    divisor_d = divisor_q;
    a_raw_d   = a_raw_q;
    sign_q_d  = sign_q_q;
    sign_r_d  = sign_r_q;
    divzero_d = divzero_q;
    shifted   = {rem_q, quot_q[WIDTH-1]};
    trial     = shifted - {1'b0, divisor_q};
    case (state_q)
      DIV_IDLE: begin
        if (start) begin
          // Magnitudes as unsigned; the most negative value maps onto itself.
          quot_d    = a[WIDTH-1] ? -a : a;
          divisor_d = b[WIDTH-1] ? -b : b;
          sign_q_d  = a[WIDTH-1] ^ b[WIDTH-1];
          sign_r_d  = a[WIDTH-1];
          divzero_d = (b == '0);
          a_raw_d   = a;
          rem_d     = '0;
          count_d   = CNT_W'(WIDTH - 1);
          state_d   = DIV_DIVIDE;
        end
      end
      DIV_DIVIDE: begin
        // Keep the difference only when the trial subtraction did not borrow.
        rem_d   = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        quot_d  = {quot_q[WIDTH-2:0], ~trial[WIDTH]};
        count_d = count_q - CNT_W'(1);
        if (count_q == '0) begin
          count_d = '0;
          state_d = DIV_FIXUP;
        end
      end
      DIV_FIXUP: begin
        state_d = DIV_IDLE;
      end
      default: begin
        state_d = DIV_IDLE;
      end
    endcase
  end

  // Divide by zero returns the dividend in HI and all ones in LO.
  assign hi_next = divzero_q ? a_raw_q : (sign_r_q ? -rem_q : rem_q);
  assign lo_next = divzero_q ? '1 : (sign_q_q ? -quot_q : quot_q);
  assign hilo_we = (state_q == DIV_FIXUP);
  assign busy    = (state_q != DIV_IDLE);

endmodule

// File: rtl/exec_alu.sv
// Execute-stage ALU: single-cycle combinational ops, architectural HI/LO
// registers, and the stall interlock around the sequential divider.
module exec_alu
  import exec_alu_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       shamt,
  input  logic [1:0]       hilo_rd,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [WIDTH-1:0] hi_q, lo_q;
  logic [WIDTH-1:0] hi_next, lo_next;
  logic             hilo_we;
  logic             div_busy;
  logic             div_start;
  logic             hilo_read;

  assign div_start = valid_in && (alu_op == ALU_DIV);
  assign hilo_read = (hilo_rd == HILO_LO) || (hilo_rd == HILO_HI);

  seq_divider #(.WIDTH(WIDTH)) u_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (div_start),
    .a       (a),
    .b       (b),
    .hi_next (hi_next),
    .lo_next (lo_next),
    .hilo_we (hilo_we),
    .busy    (div_busy)
  );

  // HI/LO change only on the divider fix-up cycle or reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (hilo_we) begin
      hi_q <= hi_next;
      lo_q <= lo_next;
    end
  end

  // Combinational result; HI/LO reads see only the committed registers.
  always_comb begin
    result = '0;
    case (alu_op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_SLL:  result = b << shamt;
      ALU_SRA:  result = $unsigned($signed(b) >>> shamt);
      ALU_SLLI: result = {b[15:0], 16'h0000};
      ALU_OR:   result = a | b;
      ALU_RS_PASS: begin
        case (hilo_rd)
          HILO_LO: result = lo_q;
          HILO_HI: result = hi_q;
          default: result = a;
        endcase
      end
      default:  result = '0;
    endcase
  end

  // Hold a DIV or HI/LO reader until the divider has committed.
  assign stall = valid_in && div_busy && ((alu_op == ALU_DIV) || hilo_read);
  assign busy  = div_busy;
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule
